// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, edge hit map and ROM content for the animated sprite
package sprite_pkg;

   localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

   // HitEdgeCode bit positions: {Left,Top,Right,Bottom}
   localparam int EDGE_LEFT   = 3;
   localparam int EDGE_TOP    = 2;
   localparam int EDGE_RIGHT  = 1;
   localparam int EDGE_BOTTOM = 0;

   localparam logic [3:0] E_L = 4'(1 << EDGE_LEFT);
   localparam logic [3:0] E_T = 4'(1 << EDGE_TOP);
   localparam logic [3:0] E_R = 4'(1 << EDGE_RIGHT);
   localparam logic [3:0] E_B = 4'(1 << EDGE_BOTTOM);

   // Sprite split into a 4x4 grid, indexed [gy][gx]; border cells report their edges
   localparam logic [3:0] HIT_MAP [4][4] = '{
      '{E_L | E_T, E_T,  E_T,  E_T | E_R},
      '{E_L,       4'h0, 4'h0, E_R      },
      '{E_L,       4'h0, 4'h0, E_R      },
      '{E_L | E_B, E_B,  E_B,  E_B | E_R}
   };

   typedef enum logic [1:0] {ANIM_RUN, ANIM_HOLD, ANIM_DONE} anim_state_t;

   // Counter width that stays legal for a count of one
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Sprite artwork: a colour ramp per frame with a sparse grid of transparent holes
   function automatic logic [7:0] rom_pixel(input int unsigned f, input int unsigned y,
                                            input int unsigned x);
      if ((x % 8) == 5 && (y % 8) == 2) return TRANSPARENT_ENCODING;
      return 8'((x * 5 + y * 11 + f * 37) % 128);
   endfunction

endpackage

// File: rtl/sprite_frame_rom.sv
// rtl/sprite_frame_rom.sv - synchronous-read multi-frame sprite ROM, addr {frame,y,x}
module sprite_frame_rom
   import sprite_pkg::*;
#(
   parameter int X_BITS     = 5,
   parameter int Y_BITS     = 5,
   parameter int NUM_FRAMES = 4
) (
   input  logic                                         clk,
   input  logic [cnt_bits(NUM_FRAMES)+Y_BITS+X_BITS-1:0] addr,
   output logic [7:0]                                   data
);

   localparam int FW = cnt_bits(NUM_FRAMES);

   // One-cycle registered read of the selected frame pixel
   always_ff @(posedge clk) begin
      data <= rom_pixel(32'(addr[X_BITS+Y_BITS +: FW]), 32'(addr[X_BITS +: Y_BITS]),
                        32'(addr[X_BITS-1:0]));
   end

endmodule

// File: rtl/animated_sprite_bitmap.sv
// rtl/animated_sprite_bitmap.sv - animated, scaled, mirrored, blinking sprite bitmap with edge codes
module animated_sprite_bitmap
   import sprite_pkg::*;
#(
   parameter int X_BITS       = 5,
   parameter int Y_BITS       = 5,
   parameter int NUM_FRAMES   = 4,
   parameter int FRAME_PERIOD = 8,
   parameter int BLINK_PERIOD = 16,
   parameter int SCALE_SHIFT  = 0
) (
   input  logic                            clk,
   input  logic                            resetN,
   input  logic                            startOfFrame,
   input  logic [10:0]                     offsetX,
   input  logic [10:0]                     offsetY,
   input  logic                            InsideRectangle,
   input  logic                            animEnable,
   input  logic                            oneShot,
   input  logic                            animRestart,
   input  logic                            blinkEnable,
   input  logic                            flipX,
   input  logic                            flipY,
   output logic                            drawingRequest,
   output logic [7:0]                      RGBout,
   output logic [3:0]                      HitEdgeCode,
   output logic [cnt_bits(NUM_FRAMES)-1:0] frameIndex,
   output logic                            animDone
);

   localparam int FW = cnt_bits(NUM_FRAMES);
   localparam int TW = cnt_bits(FRAME_PERIOD);
   localparam int BW = cnt_bits(BLINK_PERIOD);
   localparam int AW = FW + Y_BITS + X_BITS;
   localparam logic [10:0] X_SIZE = 11'(1 << X_BITS);
   localparam logic [10:0] Y_SIZE = 11'(1 << Y_BITS);

   logic [10:0]       sx, sy;
   logic              in_range_c;
   logic [X_BITS-1:0] bx_c;
   logic [Y_BITS-1:0] by_c;
   logic [AW-1:0]     rom_addr;
   logic              in_range_q, in_range_d;
   logic [1:0]        gx_q, gy_q, gx_d, gy_d;
   logic [7:0]        rom_q;
   anim_state_t       state;
   logic [TW-1:0]     tick_cnt;
   logic [BW-1:0]     blink_cnt;
   logic              visible;

   assign sx         = offsetX >> SCALE_SHIFT;
   assign sy         = offsetY >> SCALE_SHIFT;
   assign in_range_c = InsideRectangle && (sx < X_SIZE) && (sy < Y_SIZE);
   assign bx_c       = flipX ? ~sx[X_BITS-1:0] : sx[X_BITS-1:0];
   assign by_c       = flipY ? ~sy[Y_BITS-1:0] : sy[Y_BITS-1:0];

   // S1: latch ROM address, range flag and unmirrored hit-grid cell
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rom_addr   <= '0;
         in_range_q <= 1'b0;
         gx_q       <= 2'd0;
         gy_q       <= 2'd0;
      end else begin
         rom_addr   <= {frameIndex, by_c, bx_c};
         in_range_q <= in_range_c;
         gx_q       <= sx[X_BITS-1 -: 2];
         gy_q       <= sy[Y_BITS-1 -: 2];
      end
   end

   sprite_frame_rom #(
      .X_BITS    (X_BITS),
      .Y_BITS    (Y_BITS),
      .NUM_FRAMES(NUM_FRAMES)
   ) u_rom (
      .clk (clk),
      .addr(rom_addr),
      .data(rom_q)
   );

   // S2: qualifiers aligned with the ROM read data
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         in_range_d <= 1'b0;
         gx_d       <= 2'd0;
         gy_d       <= 2'd0;
      end else begin
         in_range_d <= in_range_q;
         gx_d       <= gx_q;
         gy_d       <= gy_q;
      end
   end

   assign RGBout         = (in_range_d && visible) ? rom_q : TRANSPARENT_ENCODING;
   assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);
   assign HitEdgeCode    = drawingRequest ? HIT_MAP[gy_d][gx_d] : 4'h0;

   // Animation sequencer: steps only on startOfFrame, restart wins over a same-cycle frame pulse
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= ANIM_RUN;
         frameIndex <= '0;
         tick_cnt   <= '0;
         animDone   <= 1'b0;
      end else if (animRestart) begin
         state      <= animEnable ? ANIM_RUN : ANIM_HOLD;
         frameIndex <= '0;
         tick_cnt   <= '0;
         animDone   <= 1'b0;
      end else if (startOfFrame) begin
         case (state)
            ANIM_RUN, ANIM_HOLD: begin
               if (!animEnable) begin
                  state <= ANIM_HOLD;
               end else begin
                  state <= ANIM_RUN;
                  if (tick_cnt == TW'(FRAME_PERIOD - 1)) begin
                     tick_cnt <= '0;
                     if (frameIndex == FW'(NUM_FRAMES - 1)) begin
                        if (oneShot) begin
                           state    <= ANIM_DONE;
                           animDone <= 1'b1;
                        end else begin
                           frameIndex <= '0;
                        end
                     end else begin
                        frameIndex <= frameIndex + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Blink: toggle visibility every BLINK_PERIOD frame pulses while enabled
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (!blinkEnable) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (startOfFrame) begin
         if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
            blink_cnt <= '0;
            visible   <= ~visible;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_animated_sprite_bitmap.sv
// tb/tb_animated_sprite_bitmap.sv - randomized self-checking bench for animated_sprite_bitmap
module tb_animated_sprite_bitmap;

   logic        clk = 1'b0;
   logic        resetN, startOfFrame, InsideRectangle, animEnable, oneShot;
   logic        animRestart, blinkEnable, flipX, flipY;
   logic [10:0] offsetX, offsetY;
   logic        dr0, dr1, done0, done1;
   logic [7:0]  rgb0, rgb1;
   logic [3:0]  hit0, hit1;
   logic [1:0]  fi0, fi1;

   int checks = 0;
   int errors = 0;
   int steps  = 0;

   always #5 clk = ~clk;

   animated_sprite_bitmap #(.SCALE_SHIFT(0)) dut0 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .offsetX(offsetX),
      .offsetY(offsetY), .InsideRectangle(InsideRectangle), .animEnable(animEnable),
      .oneShot(oneShot), .animRestart(animRestart), .blinkEnable(blinkEnable),
      .flipX(flipX), .flipY(flipY), .drawingRequest(dr0), .RGBout(rgb0),
      .HitEdgeCode(hit0), .frameIndex(fi0), .animDone(done0));

   animated_sprite_bitmap #(.SCALE_SHIFT(1)) dut1 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .offsetX(offsetX),
      .offsetY(offsetY), .InsideRectangle(InsideRectangle), .animEnable(animEnable),
      .oneShot(oneShot), .animRestart(animRestart), .blinkEnable(blinkEnable),
      .flipX(flipX), .flipY(flipY), .drawingRequest(dr1), .RGBout(rgb1),
      .HitEdgeCode(hit1), .frameIndex(fi1), .animDone(done1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_rom(input int f, input int y, input int x);
      if ((x % 8) == 5 && (y % 8) == 2) return 8'hFF;
      return 8'((x * 5 + y * 11 + f * 37) % 128);
   endfunction

   // {HitEdgeCode, RGBout} expected for one pixel
   function automatic logic [11:0] ref_pixel(input int shift, input int frame, input logic ins,
                                             input int ox, input int oy, input logic fx,
                                             input logic fy, input logic vis);
      int sx = ox >> shift;
      int sy = oy >> shift;
      int gx = sx / 8;
      int gy = sy / 8;
      logic [7:0] px;
      if (!ins || !vis || sx >= 32 || sy >= 32) return 12'h0FF;
      px = ref_rom(frame, fy ? 31 - sy : sy, fx ? 31 - sx : sx);
      if (px == 8'hFF) return 12'h0FF;
      return {gx == 0, gy == 0, gx == 3, gy == 3, px};
   endfunction

   function automatic int ref_frame(input int n, input logic one);
      if (one && n >= 32) return 3;
      return (n / 8) % 4;
   endfunction

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pulse_sof();
      startOfFrame = 1'b1;
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic restart_anim();
      animRestart = 1'b1;
      @(posedge clk); #1;
      animRestart = 1'b0;
      steps = 0;
   endtask

   // Random pixel stream, one new pixel per clock, checked two clocks later
   task automatic random_pixels(input int cycles, input int frame);
      logic [11:0] p0, p1, e0, e1;
      logic        have;
      have = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         InsideRectangle = ($urandom_range(0, 7) != 0);
         offsetX = 11'($urandom_range(0, 80));
         offsetY = 11'($urandom_range(0, 80));
         flipX   = 1'($urandom_range(0, 1));
         flipY   = 1'($urandom_range(0, 1));
         e0 = ref_pixel(0, frame, InsideRectangle, int'(offsetX), int'(offsetY), flipX, flipY, 1'b1);
         e1 = ref_pixel(1, frame, InsideRectangle, int'(offsetX), int'(offsetY), flipX, flipY, 1'b1);
         @(posedge clk); #1;
         if (have) begin
            check("rnd_pix0", 32'({hit0, rgb0}), 32'(p0));
            check("rnd_dr0", 32'(dr0), 32'(p0[7:0] != 8'hFF));
            check("rnd_pix1", 32'({hit1, rgb1}), 32'(p1));
            check("rnd_dr1", 32'(dr1), 32'(p1[7:0] != 8'hFF));
         end
         p0 = e0;
         p1 = e1;
         have = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic vis;
      resetN = 1'b0; startOfFrame = 1'b0; InsideRectangle = 1'b0; animEnable = 1'b0;
      oneShot = 1'b0; animRestart = 1'b0; blinkEnable = 1'b0; flipX = 1'b0; flipY = 1'b0;
      offsetX = 11'd3; offsetY = 11'd4;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", 32'(rgb0), 32'hFF);
      check("rst_dr", 32'(dr0), 32'h0);
      check("rst_hit", 32'(hit0), 32'h0);
      check("rst_frame", 32'(fi0), 32'h0);
      check("rst_done", 32'(done0), 32'h0);
      resetN = 1'b1;

      // Outside the bracket nothing is ever drawn
      for (int i = 0; i < 20; i++) begin
         offsetX = 11'($urandom_range(0, 2047));
         offsetY = 11'($urandom_range(0, 2047));
         @(posedge clk); #1;
         check("out_rgb", 32'(rgb0), 32'hFF);
         check("out_dr", 32'(dr0 | dr1), 32'h0);
         check("out_hit", 32'(hit0), 32'h0);
      end

      // Directed corners, mirroring and scaled boundary
      InsideRectangle = 1'b1;
      offsetX = 11'd0; offsetY = 11'd0;
      settle();
      check("px_0_0", 32'(rgb0), 32'(ref_rom(0, 0, 0)));
      check("hit_0_0", 32'(hit0), 32'hC);
      offsetX = 11'd31; offsetY = 11'd31;
      settle();
      check("px_31_31", 32'(rgb0), 32'(ref_rom(0, 31, 31)));
      check("hit_31_31", 32'(hit0), 32'h3);
      offsetX = 11'd0; offsetY = 11'd0; flipX = 1'b1;
      settle();
      check("px_flipx", 32'(rgb0), 32'(ref_rom(0, 0, 31)));
      check("hit_flipx", 32'(hit0), 32'hC);
      flipX = 1'b0;
      offsetX = 11'd63; offsetY = 11'd63;
      settle();
      check("s1_63_63", 32'(rgb1), 32'(ref_rom(0, 31, 31)));
      offsetX = 11'd64; offsetY = 11'd0;
      settle();
      check("s1_64_rgb", 32'(rgb1), 32'hFF);
      check("s1_64_dr", 32'(dr1), 32'h0);
      offsetX = 11'd32; offsetY = 11'd5;
      settle();
      check("s0_32_rgb", 32'(rgb0), 32'hFF);

      random_pixels(150, 0);

      // Looping animation: first fully enabled, then with random holds
      InsideRectangle = 1'b0;
      animEnable = 1'b1;
      restart_anim();
      for (int i = 0; i < 56; i++) begin
         animEnable = (i < 32) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         if (animEnable) steps++;
         pulse_sof();
         check("loop_frame", 32'(fi0), 32'(ref_frame(steps, 1'b0)));
         check("loop_done", 32'(done0), 32'h0);
      end
      animEnable = 1'b0;
      random_pixels(100, ref_frame(steps, 1'b0));
      check("hold_frame", 32'(fi1), 32'(ref_frame(steps, 1'b0)));

      // One-shot run into DONE, then restart coinciding with a frame pulse
      animEnable = 1'b1; oneShot = 1'b1;
      restart_anim();
      for (int i = 0; i < 36; i++) begin
         steps++;
         pulse_sof();
         check("os_frame", 32'(fi0), 32'(ref_frame(steps, 1'b1)));
         check("os_done", 32'(done0), 32'(steps >= 32));
      end
      animRestart = 1'b1; startOfFrame = 1'b1;
      @(posedge clk); #1;
      animRestart = 1'b0; startOfFrame = 1'b0;
      steps = 0;
      check("rs_frame", 32'(fi0), 32'h0);
      check("rs_done", 32'(done0), 32'h0);
      for (int i = 0; i < 8; i++) begin
         steps++;
         pulse_sof();
         check("rs_tick", 32'(fi0), 32'(ref_frame(steps, 1'b1)));
      end

      // Blink on an opaque pixel in the top-left cell
      animEnable = 1'b0;
      InsideRectangle = 1'b1; offsetX = 11'd1; offsetY = 11'd3; flipX = 1'b0; flipY = 1'b0;
      blinkEnable = 1'b1;
      settle();
      for (int p = 0; p < 40; p++) begin
         vis = ((p / 16) % 2) == 0;
         check("blink_dr", 32'(dr0), 32'(vis));
         check("blink_hit", 32'(hit0), vis ? 32'hC : 32'h0);
         pulse_sof();
      end
      blinkEnable = 1'b0;
      @(posedge clk); #1;
      check("blink_off", 32'(dr0), 32'h1);

      // Asynchronous reset in the middle of a clock period
      #3;
      resetN = 1'b0;
      #1;
      check("ar_rgb", 32'(rgb0), 32'hFF);
      check("ar_dr", 32'(dr0), 32'h0);
      check("ar_frame", 32'(fi0), 32'h0);
      check("ar_hit", 32'(hit0), 32'h0);
      @(posedge clk); #1;
      resetN = 1'b1;
      @(posedge clk); #1;
      check("ar_lat1", 32'(dr0), 32'h0);
      @(posedge clk); #1;
      check("ar_lat2", 32'(rgb0), 32'(ref_rom(0, 3, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
